systolic_mm_engine: RTL and testbench

Output-stationary ROWS x COLS systolic matrix-multiply engine with built-in input skewing, tile-length control, start/done sequencing, and valid/ready input and output streams. It computes C = A·B for an A tile of ROWS x K and a B tile of K x COLS, with K set at run time. The host streams one A column and one B row per beat; the engine then drains C one row per beat. It is the next-generation compute tile above the fixed-size PE array: a full engine with sequencing, backpressure and optional accumulation across tiles.

---
 rtl/systolic_mm_engine.sv | 215 +++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine.
// Includes input skew lines, K-depth sequencing, flush, and a row-by-row
// C drain with valid/ready on both the input and output streams.
module systolic_mm_engine #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 32,
  parameter int unsigned KW   = 8,
  localparam int unsigned IW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        cfg_k,
  input  logic                 acc_keep,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   a_vec,
  input  logic [COLS*DW-1:0]   b_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*ACCW-1:0] out_row,
  output logic [IW-1:0]        out_row_idx,
  output logic                 out_last
);

  localparam int unsigned FW = $clog2(ROWS + COLS) + 1;
  localparam int unsigned PW = 2 * DW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        beat_q, beat_d;
  logic [FW-1:0]        flush_q, flush_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 done_d;
  logic                 busy_q, done_q, in_ready_q, out_valid_q, out_last_q;
  logic [COLS*ACCW-1:0] out_row_q, out_row_d;
  logic                 accept_c, clr_c, acc_en_c;

  // Operand wavefronts entering each PE, and each PE's next accumulator value
  logic [DW-1:0]        a_in    [ROWS][COLS];
  logic [DW-1:0]        b_in    [ROWS][COLS];
  logic [ACCW-1:0]      acc_nxt [ROWS][COLS];

  assign acc_en_c = (state_q == S_LOAD) || (state_q == S_FLUSH);

  // A skew: lane i is delayed i+1 cycles; bubbles inject zeros
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic [DW-1:0] sr_q [i+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) sr_q[s] <= '0;
      end else begin
        sr_q[0] <= accept_c ? a_vec[i*DW +: DW] : '0;
        for (int s = 1; s <= i; s++) sr_q[s] <= sr_q[s-1];
      end
    end
    assign a_in[i][0] = sr_q[i];
  end

  // B skew: lane j is delayed j+1 cycles; bubbles inject zeros
  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic [DW-1:0] sr_q [j+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= j; s++) sr_q[s] <= '0;
      end else begin
        sr_q[0] <= accept_c ? b_vec[j*DW +: DW] : '0;
        for (int s = 1; s <= j; s++) sr_q[s] <= sr_q[s-1];
      end
    end
    assign b_in[0][j] = sr_q[j];
  end

  // PE grid: MAC into a stationary accumulator, forward a right and b down
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [ACCW-1:0]      acc_q;
      logic signed [PW-1:0] prod_c;

      assign prod_c = PW'($signed(a_in[i][j])) * PW'($signed(b_in[i][j]));
      assign acc_nxt[i][j] = clr_c    ? '0 :
                             acc_en_c ? acc_q + ACCW'(prod_c) : acc_q;

      // Accumulator register; wraps modulo 2^ACCW
      always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_nxt[i][j];
      end

      if (j < COLS - 1) begin : g_fwd_a
        logic [DW-1:0] a_q;
        // Forward a to the right neighbour
        always_ff @(posedge clk) begin
          if (rst) a_q <= '0;
          else     a_q <= a_in[i][j];
        end
        assign a_in[i][j+1] = a_q;
      end

      if (i < ROWS - 1) begin : g_fwd_b
        logic [DW-1:0] b_q;
        // Forward b to the neighbour below
        always_ff @(posedge clk) begin
          if (rst) b_q <= '0;
          else     b_q <= b_in[i][j];
        end
        assign b_in[i+1][j] = b_q;
      end
    end
  end

  // Sequencer next-state: tile start, beat counting, flush, row drain
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    beat_d   = beat_q;
    flush_d  = flush_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    clr_c    = 1'b0;
    accept_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = cfg_k;
          beat_d  = '0;
          idx_d   = '0;
          clr_c   = ~acc_keep;
          state_d = (cfg_k != '0) ? S_LOAD : S_DRAIN;
        end
      end
      S_LOAD: begin
        accept_c = in_valid;
        if (in_valid) begin
          beat_d = beat_q + KW'(1);
          if (beat_d == k_q) begin
            state_d = S_FLUSH;
            flush_d = FW'(ROWS + COLS - 1);
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q - FW'(1);
        if (flush_q == FW'(1)) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == IW'(ROWS - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next output row: selected accumulator row, including this cycle's MAC
  always_comb begin
    out_row_d = '0;
    if (state_d == S_DRAIN) begin
      for (int j = 0; j < COLS; j++) out_row_d[j*ACCW +: ACCW] = acc_nxt[idx_d][j];
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      flush_q     <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_q      <= beat_d;
      flush_q     <= flush_d;
      idx_q       <= idx_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_DRAIN);
      out_last_q  <= (state_d == S_DRAIN) && (idx_d == IW'(ROWS - 1));
      out_row_q   <= out_row_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_row     = out_row_q;
  assign out_row_idx = idx_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: directed and random tiles
// compared against a plain matrix-product reference model.
module tb_systolic_mm_engine;
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned ACCW = 16;
  localparam int unsigned KW   = 8;
  localparam int unsigned IW   = 2;
  localparam int unsigned AW   = ROWS * DW;
  localparam int unsigned BW   = COLS * DW;
  localparam int          KMAX = 16;

  logic                 clk = 1'b0;
  logic                 rst, start, acc_keep, in_valid, out_ready;
  logic [KW-1:0]        cfg_k;
  logic [AW-1:0]        a_vec;
  logic [BW-1:0]        b_vec;
  logic                 busy, done, in_ready, out_valid, out_last;
  logic [COLS*ACCW-1:0] out_row;
  logic [IW-1:0]        out_row_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(ACCW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .acc_keep(acc_keep),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last)
  );

  // Tile operands and reference accumulators
  int     ga  [ROWS][KMAX];
  int     gb  [KMAX][COLS];
  longint mdl [ROWS][COLS];

  // What the runner observed for the last tile
  logic [COLS*ACCW-1:0] obs_row [ROWS];
  int obs_idx [ROWS];
  bit obs_last [ROWS];
  int obs_n, done_lat;
  bit timed_out, hold_bad, both_high, last_bad, first_ok;

  function automatic void model_tile(input int k, input bit keep);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (!keep) mdl[r][c] = 0;
        for (int kk = 0; kk < k; kk++) mdl[r][c] += longint'(ga[r][kk]) * longint'(gb[kk][c]);
      end
  endfunction

  function automatic logic [COLS*ACCW-1:0] exp_row(input int r);
    logic [COLS*ACCW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*ACCW +: ACCW] = ACCW'(mdl[r][c]);
    return v;
  endfunction

  function automatic logic [COLS*ACCW-1:0] const_row(input int base, input int step);
    logic [COLS*ACCW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*ACCW +: ACCW] = ACCW'(base + c * step);
    return v;
  endfunction

  function automatic void set_identity();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KMAX; k++) ga[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < KMAX; k++)
      for (int c = 0; c < COLS; c++) gb[k][c] = k * 4 + c + 1;
  endfunction

  // Runs one tile starting at the current negedge; records rows and timing
  task automatic run_tile(input int k, input bit keep, input bit stall, input int bp_row, input int bp_len);
    int beat = 0, p = 0, cyc = 0, hold = 0;
    logic [COLS*ACCW-1:0] hrow;
    logic [IW-1:0] hidx;
    obs_n = 0; done_lat = -1; timed_out = 1; hold_bad = 0; both_high = 0; last_bad = 0; first_ok = 0;
    hrow = '0; hidx = '0;
    start = 1'b1; cfg_k = KW'(k); acc_keep = keep; out_ready = 1'b1;
    in_valid = 1'($urandom_range(0, 1)); a_vec = AW'($urandom); b_vec = BW'($urandom);
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy && done) both_high = 1;
      if (cyc == 1) first_ok = busy && (in_ready == (k != 0));
      if (done) begin done_lat = cyc; timed_out = 0; break; end
      if (busy && $urandom_range(0, 3) == 0) begin
        start = 1'b1; cfg_k = KW'($urandom_range(0, 3)); acc_keep = 1'b0;
      end
      if (in_ready) begin
        in_valid = stall ? (p % 3 == 0) : 1'b1;
        p++;
        if (in_valid && beat < KMAX) begin
          for (int i = 0; i < ROWS; i++) a_vec[i*DW +: DW] = DW'(ga[i][beat]);
          for (int j = 0; j < COLS; j++) b_vec[j*DW +: DW] = DW'(gb[beat][j]);
          beat++;
        end else begin
          a_vec = AW'($urandom); b_vec = BW'($urandom);
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1)); a_vec = AW'($urandom); b_vec = BW'($urandom);
      end
      if (out_valid) begin
        if (out_last !== (out_row_idx == IW'(ROWS - 1))) last_bad = 1;
        if (obs_n == bp_row && hold < bp_len) begin
          if (hold == 0) begin hrow = out_row; hidx = out_row_idx; end
          else if (out_row !== hrow || out_row_idx !== hidx) hold_bad = 1;
          hold++;
          out_ready = 1'b0;
        end else begin
          if (hold > 0 && obs_n == bp_row && (out_row !== hrow || out_row_idx !== hidx)) hold_bad = 1;
          out_ready = 1'b1;
          if (obs_n < ROWS) begin
            obs_row[obs_n] = out_row; obs_idx[obs_n] = int'(out_row_idx); obs_last[obs_n] = out_last;
          end
          obs_n++;
        end
      end else begin
        if (hold > 0 && obs_n == bp_row) hold_bad = 1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_k = '0; acc_keep = 1'b0; a_vec = '0; b_vec = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done); end
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset ready/valid: got %b/%b want 0/0", in_ready, out_valid); end
    n_tests++; if (out_row !== '0) begin n_fail++; $display("FAIL reset out_row: got %h want 0", out_row); end
    n_tests++; if (out_row_idx !== '0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset idx/last: got %0d/%b want 0/0", out_row_idx, out_last); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    set_identity(); model_tile(4, 0);
    run_tile(4, 0, 0, -1, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL identity timeout: no done within bound"); end
    n_tests++; if (first_ok !== 1'b1) begin n_fail++; $display("FAIL identity first cycle busy/in_ready: got %b want 1", first_ok); end
    n_tests++; if (done_lat != 16) begin n_fail++; $display("FAIL identity done latency: got %0d want 16", done_lat); end
    n_tests++; if (obs_n != ROWS) begin n_fail++; $display("FAIL identity rows: got %0d want %0d", obs_n, ROWS); end
    for (int r = 0; r < ROWS; r++) begin
      n_tests++;
      if (obs_row[r] !== const_row(r * 4 + 1, 1)) begin n_fail++; $display("FAIL identity row%0d: got %h want %h", r, obs_row[r], const_row(r * 4 + 1, 1)); end
      n_tests++;
      if (obs_idx[r] != r || obs_last[r] !== (r == ROWS - 1)) begin n_fail++; $display("FAIL identity idx/last row%0d: got %0d/%b want %0d/%b", r, obs_idx[r], obs_last[r], r, r == ROWS - 1); end
    end
    n_tests++; if (last_bad) begin n_fail++; $display("FAIL identity out_last consistency: got bad want ok"); end
  endtask

  task automatic test_signed_wrap();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < 4; k++) ga[r][k] = -128;
    for (int k = 0; k < 4; k++) for (int c = 0; c < COLS; c++) gb[k][c] = -128;
    run_tile(4, 0, 0, -1, 0);
    for (int r = 0; r < ROWS; r++) begin
      n_tests++; if (obs_row[r] !== const_row(0, 0)) begin n_fail++; $display("FAIL wrap_neg row%0d: got %h want %h", r, obs_row[r], const_row(0, 0)); end
    end
    for (int k = 0; k < 4; k++) for (int c = 0; c < COLS; c++) gb[k][c] = 127;
    run_tile(4, 0, 0, -1, 0);
    for (int r = 0; r < ROWS; r++) begin
      n_tests++; if (obs_row[r] !== const_row(512, 0)) begin n_fail++; $display("FAIL wrap_mixed row%0d: got %h want %h", r, obs_row[r], const_row(512, 0)); end
    end
  endtask

  task automatic test_stalls();
    set_identity(); model_tile(4, 0);
    run_tile(4, 0, 1, -1, 0);
    n_tests++; if (done_lat != 22) begin n_fail++; $display("FAIL stalls done latency: got %0d want 22", done_lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_tests++; if (obs_row[r] !== exp_row(r)) begin n_fail++; $display("FAIL stalls row%0d: got %h want %h", r, obs_row[r], exp_row(r)); end
    end
  endtask

  task automatic test_backpressure();
    set_identity(); model_tile(4, 0);
    run_tile(4, 0, 0, 1, 5);
    n_tests++; if (hold_bad) begin n_fail++; $display("FAIL backpressure hold stability: got unstable want stable"); end
    n_tests++; if (obs_n != ROWS) begin n_fail++; $display("FAIL backpressure rows: got %0d want %0d", obs_n, ROWS); end
    n_tests++; if (done_lat != 21) begin n_fail++; $display("FAIL backpressure done latency: got %0d want 21", done_lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_tests++;
      if (obs_row[r] !== exp_row(r) || obs_idx[r] != r) begin n_fail++; $display("FAIL backpressure row%0d: got %h idx %0d want %h idx %0d", r, obs_row[r], obs_idx[r], exp_row(r), r); end
    end
  endtask

  task automatic test_acc_keep();
    set_identity();
    model_tile(4, 0); run_tile(4, 0, 0, -1, 0);
    model_tile(4, 1); run_tile(4, 1, 0, -1, 0);
    n_tests++; if (done_lat != 16) begin n_fail++; $display("FAIL back_to_back done latency: got %0d want 16", done_lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_tests++; if (obs_row[r] !== const_row(2 * (r * 4 + 1), 2)) begin n_fail++; $display("FAIL keep_double row%0d: got %h want %h", r, obs_row[r], const_row(2 * (r * 4 + 1), 2)); end
    end
    model_tile(4, 0); run_tile(4, 0, 0, -1, 0);
    for (int r = 0; r < ROWS; r++) begin
      n_tests++; if (obs_row[r] !== exp_row(r)) begin n_fail++; $display("FAIL keep_clear row%0d: got %h want %h", r, obs_row[r], exp_row(r)); end
    end
    model_tile(0, 0); run_tile(0, 0, 0, -1, 0);
    n_tests++; if (done_lat != 5) begin n_fail++; $display("FAIL k0 done latency: got %0d want 5", done_lat); end
    for (int r = 0; r < ROWS; r++) begin
      n_tests++; if (obs_row[r] !== const_row(0, 0)) begin n_fail++; $display("FAIL k0 row%0d: got %h want 0", r, obs_row[r]); end
    end
  endtask

  task automatic test_reset_flush();
    bit saw_done = 0, saw_busy = 0;
    set_identity();
    @(negedge clk);
    start = 1'b1; cfg_k = KW'(4); acc_keep = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      start = (b == 0);
      cfg_k = (b == 0) ? KW'(1) : KW'(4);
      if (b == 3) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_while_busy in_ready at beat3: got %b want 1", in_ready); end
      end
      in_valid = 1'b1;
      for (int i = 0; i < ROWS; i++) a_vec[i*DW +: DW] = DW'(ga[i][b]);
      for (int j = 0; j < COLS; j++) b_vec[j*DW +: DW] = DW'(gb[b][j]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush state busy/rdy/vld: got %b%b%b want 100", busy, in_ready, out_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, done, in_ready, out_valid, out_last} !== 5'b0 || out_row !== '0 || out_row_idx !== '0) begin
      n_fail++; $display("FAIL reset_in_flush outputs: got b%b d%b r%b v%b l%b row %h idx %0d want all 0", busy, done, in_ready, out_valid, out_last, out_row, out_row_idx);
    end
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (busy) saw_busy = 1;
    end
    n_tests++; if (saw_done || saw_busy) begin n_fail++; $display("FAIL reset_in_flush aftermath done/busy: got %b/%b want 0/0", saw_done, saw_busy); end
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mdl[r][c] = 0;
    model_tile(4, 1); run_tile(4, 1, 0, -1, 0);
    for (int r = 0; r < ROWS; r++) begin
      n_tests++; if (obs_row[r] !== const_row(r * 4 + 1, 1)) begin n_fail++; $display("FAIL after_reset row%0d: got %h want %h", r, obs_row[r], const_row(r * 4 + 1, 1)); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int k;
      bit keep, stall;
      k = $urandom_range(1, 12); keep = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1));
      for (int r = 0; r < ROWS; r++) for (int kk = 0; kk < KMAX; kk++) ga[r][kk] = int'($urandom_range(0, 255)) - 128;
      for (int kk = 0; kk < KMAX; kk++) for (int c = 0; c < COLS; c++) gb[kk][c] = int'($urandom_range(0, 255)) - 128;
      model_tile(k, keep);
      run_tile(k, keep, stall, $urandom_range(0, 3), $urandom_range(0, 4));
      n_tests++;
      if (timed_out || hold_bad || both_high || last_bad || obs_n != ROWS) begin
        n_fail++; $display("FAIL random%0d protocol: got to%b hold%b both%b last%b rows%0d want 0 0 0 0 %0d", n, timed_out, hold_bad, both_high, last_bad, obs_n, ROWS);
      end
      for (int r = 0; r < ROWS; r++) begin
        n_tests++; if (obs_row[r] !== exp_row(r)) begin n_fail++; $display("FAIL random%0d row%0d (k=%0d keep=%0d): got %h want %h", n, r, k, keep, obs_row[r], exp_row(r)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed_wrap();
    test_stalls();
    test_backpressure();
    test_acc_keep();
    test_reset_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
